// File: rtl/aes_key_sched_seq_if.sv
// Start/key request and round-key valid/yumi port of the sequential AES key schedule.
interface aes_key_sched_seq_if;
  logic         start_v;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         ready;
  logic         rk_v;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_yumi;

  modport slave (
    input  start_v, mode, key, rk_yumi,
    output ready, rk_v, rk, rk_idx, rk_last
  );

  modport master (
    output start_v, mode, key, rk_yumi,
    input  ready, rk_v, rk, rk_idx, rk_last
  );
endinterface

// File: rtl/aes_key_sched_seq.sv
// AES-128/192/256 key expansion, one schedule word per cycle through one 4-byte S-box bank,
// round keys presented on a valid/yumi port with back-pressure.
module aes_key_sched_seq #(
  parameter int unsigned max_nk_p = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  aes_key_sched_seq_if.slave  kif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [0:255][7:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return Sbox[b];
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [0:7][31:0] r_key;
  logic [3:0]       r_nk;
  logic [3:0]       r_nr;
  logic [5:0]       r_i;
  logic [2:0]       r_cnt;
  logic [7:0]       r_rcon;
  logic [31:0]      r_win [max_nk_p];
  logic [31:0]      r_acc [3];
  logic [127:0]     r_rk;
  logic             r_rk_v;
  logic [3:0]       r_rk_idx;
  logic             r_rk_last;

  logic [3:0]  w_nk_sel;
  logic [3:0]  w_nr_sel;
  logic        w_legal;
  logic        w_start;
  logic        w_adv;
  logic        w_rot;
  logic        w_last_word;
  logic        w_rk_done;
  logic [31:0] w_prev;
  logic [31:0] w_old;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_t;
  logic [31:0] w_word;

  always_comb begin
    w_nk_sel = 4'd0;
    unique case (kif.mode)
      2'd0:    w_nk_sel = 4'd4;
      2'd1:    w_nk_sel = 4'd6;
      2'd2:    w_nk_sel = 4'd8;
      default: w_nk_sel = 4'd0;
    endcase
    w_nr_sel = w_nk_sel + 4'd6;
    w_legal  = (kif.mode != 2'd3) && (32'(w_nk_sel) <= max_nk_p);
  end

  assign w_start = (r_state == StIdle) && kif.start_v && w_legal;

  // A round-key-completing word waits while the previous round key is still unconsumed.
  assign w_adv = (r_state == StRun) &&
                 !((r_i[1:0] == 2'd3) && r_rk_v && !kif.rk_yumi);
  assign w_rk_done   = w_adv && (r_i[1:0] == 2'd3);
  assign w_last_word = (r_i == {r_nr, 2'b11});
  assign w_rot       = (r_i >= 6'(r_nk)) && (r_cnt == 3'd0);

  assign w_prev    = r_win[0];
  assign w_old     = r_win[3'(r_nk - 4'd1)];
  assign w_sub_in  = (r_cnt == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                      sbox(w_sub_in[15:8]), sbox(w_sub_in[7:0])};

  always_comb begin
    w_t = w_prev;
    if (r_cnt == 3'd0) begin
      w_t = w_sub_out ^ {r_rcon, 24'h0};
    end else if ((r_nk == 4'd8) && (r_cnt == 3'd4)) begin
      w_t = w_sub_out;
    end
    w_word = (r_i < 6'(r_nk)) ? r_key[r_i[2:0]] : (w_old ^ w_t);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StRun;
      StRun:   if (w_adv && w_last_word) w_state_nxt = StDrain;
      StDrain: if (r_rk_v && r_rk_last && kif.rk_yumi) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_key     <= '0;
      r_nk      <= '0;
      r_nr      <= '0;
      r_i       <= '0;
      r_cnt     <= '0;
      r_rcon    <= '0;
      r_rk      <= '0;
      r_rk_v    <= 1'b0;
      r_rk_idx  <= '0;
      r_rk_last <= 1'b0;
      for (int k = 0; k < int'(max_nk_p); k++) r_win[k] <= '0;
      for (int k = 0; k < 3; k++) r_acc[k] <= '0;
    end else begin
      if (w_start) begin
        r_key  <= kif.key;
        r_nk   <= w_nk_sel;
        r_nr   <= w_nr_sel;
        r_i    <= '0;
        r_cnt  <= '0;
        r_rcon <= 8'h01;
      end
      if (w_adv) begin
        for (int k = int'(max_nk_p) - 1; k > 0; k--) r_win[k] <= r_win[k-1];
        r_win[0] <= w_word;
        r_i      <= r_i + 6'd1;
        r_cnt    <= (r_cnt == 3'(r_nk - 4'd1)) ? 3'd0 : r_cnt + 3'd1;
        if (w_rot) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        if (r_i[1:0] != 2'd3) r_acc[r_i[1:0]] <= w_word;
      end
      if (w_rk_done) begin
        r_rk      <= {r_acc[0], r_acc[1], r_acc[2], w_word};
        r_rk_v    <= 1'b1;
        r_rk_idx  <= r_i[5:2];
        r_rk_last <= (r_i[5:2] == r_nr);
      end else if (kif.rk_yumi) begin
        r_rk_v <= 1'b0;
      end
    end
  end

  assign kif.ready   = (r_state == StIdle);
  assign kif.rk_v    = r_rk_v;
  assign kif.rk      = r_rk;
  assign kif.rk_idx  = r_rk_idx;
  assign kif.rk_last = r_rk_last;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq using FIPS-197 key expansion vectors.
module tb_aes_key_sched_seq;

  localparam logic [127:0] Key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] Key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] Exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  aes_key_sched_seq_if kif ();

  aes_key_sched_seq #(.max_nk_p(8)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .kif      (kif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [255:0] k);
    kif.mode    = m;
    kif.key     = k;
    kif.start_v = 1'b1;
    tick();
    kif.start_v = 1'b0;
  endtask

  // AES-128 with yumi held; optionally fires a busy-time start that must be ignored.
  task automatic run128(input bit disturb, input string tag);
    start_run(2'd0, {Key128, 128'h0});
    for (int r = 0; r <= 10; r++) begin
      for (int s = 1; s <= 4; s++) begin
        kif.start_v = disturb && (r == 1);
        if (disturb && r == 1) begin
          kif.mode = 2'd2;
          kif.key  = Key256;
        end
        tick();
        if (r == 0 && s == 3) check({tag, "_rk_v_early"}, 128'(kif.rk_v), 128'd0);
      end
      check({tag, "_rk_v"}, 128'(kif.rk_v), 128'd1);
      check({tag, "_rk"}, kif.rk, Exp128[r]);
      check({tag, "_idx"}, 128'(kif.rk_idx), 128'(r));
      check({tag, "_last"}, 128'(kif.rk_last), 128'(r == 10));
      if (r == 5) check({tag, "_busy"}, 128'(kif.ready), 128'd0);
    end
    kif.start_v = 1'b0;
    tick();
    check({tag, "_ready_end"}, 128'(kif.ready), 128'd1);
    check({tag, "_rk_v_end"}, 128'(kif.rk_v), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    int taken;
    int hold_bad;

    kif.start_v = 1'b0;
    kif.mode    = 2'd0;
    kif.key     = '0;
    kif.rk_yumi = 1'b1;
    held        = '0;
    taken       = 0;
    hold_bad    = 0;
    tick();
    tick();
    check("rst_ready", 128'(kif.ready), 128'd1);
    check("rst_rk_v", 128'(kif.rk_v), 128'd0);
    check("rst_rk", kif.rk, 128'd0);
    check("rst_idx", 128'(kif.rk_idx), 128'd0);
    check("rst_last", 128'(kif.rk_last), 128'd0);
    reset_n = 1'b1;
    tick();

    run128(1'b0, "aes128");

    start_run(2'd2, Key256);
    for (int r = 0; r <= 14; r++) begin
      repeat (4) tick();
      check("aes256_rk_v", 128'(kif.rk_v), 128'd1);
      check("aes256_idx", 128'(kif.rk_idx), 128'(r));
      check("aes256_last", 128'(kif.rk_last), 128'(r == 14));
      if (r == 0) check("aes256_rk0", kif.rk, Key256[255:128]);
      if (r == 1) check("aes256_rk1", kif.rk, Key256[127:0]);
      if (r == 2) check("aes256_rk2_w0", 128'(kif.rk[127:96]), 128'h9ba35411);
      if (r == 14) check("aes256_rk14", kif.rk, 128'hfe4890d1e6188d0b046df344706c631e);
    end
    tick();
    check("aes256_ready_end", 128'(kif.ready), 128'd1);

    start_run(2'd1, {Key192, 64'h0});
    for (int r = 0; r <= 12; r++) begin
      repeat (4) tick();
      check("aes192_idx", 128'(kif.rk_idx), 128'(r));
      check("aes192_last", 128'(kif.rk_last), 128'(r == 12));
      if (r == 1) check("aes192_rk1", kif.rk, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      if (r == 12) check("aes192_rk12", kif.rk, 128'he98ba06f448c773c8ecc720401002202);
    end
    tick();
    check("aes192_ready_end", 128'(kif.ready), 128'd1);

    // Back-pressure: rk3 held unconsumed for 10 cycles.
    start_run(2'd0, {Key128, 128'h0});
    for (int cyc = 1; cyc <= 120; cyc++) begin
      tick();
      if (cyc == 16) begin
        held = kif.rk;
        check("bp_rk3_idx", 128'(kif.rk_idx), 128'd3);
      end
      if (cyc > 16 && cyc < 26 &&
          (kif.rk !== held || kif.rk_idx !== 4'd3 || kif.rk_v !== 1'b1)) hold_bad++;
      kif.rk_yumi = !(cyc >= 16 && cyc < 26);
      if (kif.rk_v && kif.rk_yumi) begin
        check("bp_idx", 128'(kif.rk_idx), 128'(taken));
        check("bp_rk", kif.rk, (taken < 11) ? Exp128[taken] : 128'd0);
        check("bp_last", 128'(kif.rk_last), 128'(taken == 10));
        taken++;
      end
      if (kif.ready && taken >= 11) break;
    end
    kif.rk_yumi = 1'b1;
    check("bp_taken", 128'(taken), 128'd11);
    check("bp_hold_stable", 128'(hold_bad), 128'd0);
    check("bp_ready_end", 128'(kif.ready), 128'd1);

    // Illegal mode start is ignored.
    kif.mode    = 2'd3;
    kif.key     = Key256;
    kif.start_v = 1'b1;
    tick();
    check("illegal_ready", 128'(kif.ready), 128'd1);
    check("illegal_rk_v", 128'(kif.rk_v), 128'd0);
    tick();
    check("illegal_ready2", 128'(kif.ready), 128'd1);
    kif.start_v = 1'b0;

    run128(1'b1, "busy_start");

    // Asynchronous reset in the middle of an AES-256 run.
    start_run(2'd2, Key256);
    repeat (20) tick();
    check("pre_rst_rk_v", 128'(kif.rk_v), 128'd1);
    check("pre_rst_idx", 128'(kif.rk_idx), 128'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(kif.ready), 128'd1);
    check("mid_rst_rk_v", 128'(kif.rk_v), 128'd0);
    check("mid_rst_rk", kif.rk, 128'd0);
    check("mid_rst_idx", 128'(kif.rk_idx), 128'd0);
    check("mid_rst_last", 128'(kif.rk_last), 128'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rk_v", 128'(kif.rk_v), 128'd0);

    run128(1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_seq.md
Name: aes_key_sched_seq

Overview:
Sequential AES key-schedule engine that expands an AES-128, AES-192 or AES-256 cipher key into its full set of 128-bit round keys. The key length is selected at run time. The engine produces one 32-bit schedule word per cycle through a single shared 4-byte S-box bank, and presents each round key on a valid/yumi output port that tolerates back-pressure. It feeds the iterative cipher datapath and replaces the combinational single-round key block. It adds multi-length support, correct Rcon past round 8, and flow control.

Parameters:
max_nk_p, 8, largest supported key length in 32-bit words (4, 6 or 8); any mode needing more words is illegal.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
start_v_i  in  1  start request; accepted when start_v_i & ready_o
mode_i  in  2  key length: 0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = illegal
key_i  in  256  cipher key; FIPS-197 word w[j] = key_i[255-32j -: 32], first key byte in the MSB; unused low words ignored
ready_o  out  1  idle, able to accept start
rk_v_o  out  1  round key valid
rk_o  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96]
rk_idx_o  out  4  round index r of rk_o
rk_last_o  out  1  rk_o is round Nr (qualified by rk_v_o)
rk_yumi_i  in  1  consumer takes rk_o this cycle; legal only while rk_v_o

Behaviour:
- Reset values: ready_o=1, rk_v_o=0, rk_o=0, rk_idx_o=0, rk_last_o=0. All internal state is cleared. Reset mid-expansion aborts with no further output.
- States:
  - IDLE: ready_o=1.
  - On start_v_i with a legal mode (mode_i != 3 and Nk <= max_nk_p): latch key_i and Nk/Nr, set word index i=0, set rcon=8'h01, go to RUN.
  - An illegal-mode start is ignored and the engine stays in IDLE.
- RUN (ready_o=0): one word is produced per non-stalled cycle, in this order:
  - i < Nk: the word is w[i], taken directly from the latched key.
  - i >= Nk: the word is w[i] = w[i-Nk] ^ t, where t is chosen as follows:
    - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. Rcon then advances by GF(2^8) xtime (0x80 -> 0x1b).
    - Nk == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
    - otherwise: t = w[i-1].
  - RotWord rotates bytes left: {b1, b2, b3, b0}.
  - A sliding window of the last Nk words supplies w[i-Nk] and w[i-1].
- Words with i mod 4 in 0..2 go to a 3-word accumulator. The word with i mod 4 == 3 is combined with the accumulator into rk_o, setting rk_v_o=1, rk_idx_o=i/4 and rk_last_o=(i/4==Nr).
- Stall rule: a word with i mod 4 == 3 is not produced while rk_v_o & ~rk_yumi_i. If yumi and completion of the next round key occur in the same cycle, rk_o is reloaded and rk_v_o stays 1. Otherwise yumi clears rk_v_o on the next edge.
- Latency: the start edge is cycle 0. With no stalls, round r is valid after the edge of cycle 4r+4. A consumer that holds yumi high gets one round key every 4 cycles. The total run is 4(Nr+1) word cycles: 44 (AES-128), 52 (AES-192) or 60 (AES-256).
- Completion: after the last word is produced, the state is DRAIN. When rk_last_o is yumi'd, the engine returns to IDLE and ready_o=1 on the next edge. A start in that same cycle is not accepted because ready_o is still 0.
- start_v_i is ignored while not in IDLE.
- The S-box is the codebase's combinational byte S-box ROM, instantiated 4 times. There is no registered path inside the word computation.

Test Plan:
1. AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, yumi held 1 -> rk0 equals the key at cycle 4; rk1[127:96]=a0fafe17; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last_o=1 at cycle 44; ready_o=1 at cycle 45.
2. AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk1=1f352c073b6108d72d9810a30914dff4; rk2[127:96]=9ba35411; rk14=fe4890d1e6188d0b046df344706c631e, idx 14.
3. AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk12=e98ba06f448c773c8ecc720401002202, rk_last_o=1 at cycle 52.
4. Back-pressure: same as test 1 with yumi deasserted for 10 cycles at rk3 -> rk_o/rk_idx_o held stable; no round skipped or duplicated; final values unchanged.
5. mode_i=3 with start, plus start while busy -> ignored: ready_o stays 1 in the first case; the in-flight sequence is undisturbed in the second.
6. reset_n_i pulsed low at cycle 20 of an AES-256 run -> all outputs at reset values immediately; a fresh AES-128 start then reproduces test 1 exactly.
